// File: rtl/kamikaze_imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : kamikaze_imem_arbiter_if
// Brief     : IF, LS and memory-port bundles around the kamikaze_imem_arbiter.
// Revision  : 1.0 - initial release
// ============================================================================
interface kamikaze_imem_arbiter_if;

    // Instruction fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    // Load/store port
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;

    // Unified memory port
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    // Environment view: requesters plus memory
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/kamikaze_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : kamikaze_imem_arbiter
// Brief    : Shares one 32-bit memory port between IF and LS, tracks owners of
//            outstanding transactions and routes responses back in order.
//            Define KAMIKAZE_ARB_RR_EN for round-robin instead of LS priority.
// Revision : 1.0 - initial release
// ============================================================================
module kamikaze_imem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int RESET_OWNER_RR  = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    kamikaze_imem_arbiter_if.slave bus
);

    localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic               c_OWNER_IF = 1'b0;
    localparam logic               c_OWNER_LS = 1'b1;

    generate
        if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 8) ||
            ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) ||
            (RESET_OWNER_RR < 0) || (RESET_OWNER_RR > 1)) begin : g_param_check
            $error("kamikaze_imem_arbiter: illegal parameter value");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Owner queue state
    // ------------------------------------------------------------------------
    logic [MAX_OUTSTANDING-1:0] r_owner;
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_CNT_W-1:0]         r_count;

    logic        w_full;
    logic        w_empty;
    logic        w_any_req;
    logic        w_sel_ls;
    logic        w_mem_req;
    logic        w_xfer;
    logic        w_pop;
    logic        w_head;
    logic [31:0] w_addr;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    assign w_full    = (r_count == c_CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_any_req = bus.if_req | bus.ls_req;

    // ------------------------------------------------------------------------
    // Requester selection
    // ------------------------------------------------------------------------
`ifdef KAMIKAZE_ARB_RR_EN
    localparam logic c_RR_INIT = 1'(RESET_OWNER_RR);

    // r_rr names the requester favoured on the next contended cycle (1 = LS)
    logic r_rr;

    assign w_sel_ls = bus.ls_req & (~bus.if_req | r_rr);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rr <= c_RR_INIT;
        end else if (w_xfer) begin
            r_rr <= ~w_sel_ls;
        end
    end
`else
    assign w_sel_ls = bus.ls_req;
`endif

    // Reset gates the request path so nothing is granted while rst_i is low
    assign w_mem_req = rst_i & w_any_req & ~w_full;
    assign w_xfer    = w_mem_req & bus.mem_gnt;

    // Responses with nothing outstanding are dropped silently
    assign w_pop  = rst_i & bus.mem_rvalid & ~w_empty;
    assign w_head = r_owner[r_rd_ptr];

    // ------------------------------------------------------------------------
    // Memory request path
    // ------------------------------------------------------------------------
    assign w_addr        = w_sel_ls ? bus.ls_addr : bus.if_addr;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_sel_ls & bus.ls_we;
    assign bus.mem_be    = w_sel_ls ? bus.ls_be : 4'hF;
    assign bus.mem_addr  = w_addr & ~32'h0000_0003;
    assign bus.mem_wdata = w_sel_ls ? bus.ls_wdata : 32'h0000_0000;

    assign bus.if_gnt = w_xfer & ~w_sel_ls;
    assign bus.ls_gnt = w_xfer &  w_sel_ls;

    // ------------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------------
    assign bus.if_rvalid = w_pop & (w_head == c_OWNER_IF);
    assign bus.ls_rvalid = w_pop & (w_head == c_OWNER_LS);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.ls_rdata  = bus.mem_rdata;

    // ------------------------------------------------------------------------
    // Owner queue update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_owner  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_xfer) begin
                r_owner[r_wr_ptr] <= w_sel_ls;
                r_wr_ptr          <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_xfer, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kamikaze_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_kamikaze_imem_arbiter
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kamikaze_imem_arbiter;

    localparam int MAX_OUT = 2;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    kamikaze_imem_arbiter_if bus();

    kamikaze_imem_arbiter #(
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_OWNER_RR  (0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.if_req     = 1'b0;
        bus.if_addr    = 32'h0;
        bus.ls_req     = 1'b0;
        bus.ls_we      = 1'b0;
        bus.ls_be      = 4'h0;
        bus.ls_addr    = 32'h0;
        bus.ls_wdata   = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model state
    int q[$];
    bit rr_m;
    bit if_act, ls_act;
    bit full, win_ls, e_req, e_xfer, pop, head_ls;

    initial begin
        idle();
        rst_n = 1'b0;

        // Reset state, including requests presented while in reset
        @(negedge clk);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_if_rvalid", 32'(bus.if_rvalid), 0);
        bus.if_req = 1'b1; bus.ls_req = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
        #1;
        check("rst_if_gnt", 32'(bus.if_gnt), 0);
        check("rst_ls_gnt", 32'(bus.ls_gnt), 0);
        check("rst_req_held", 32'(bus.mem_req), 0);
        check("rst_ls_rvalid", 32'(bus.ls_rvalid), 0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // Single IF read with unaligned address
        @(negedge clk);
        idle(); bus.if_req = 1'b1; bus.if_addr = 32'h6; bus.mem_gnt = 1'b1;
        #1;
        check("t1_if_gnt", 32'(bus.if_gnt), 1);
        check("t1_ls_gnt", 32'(bus.ls_gnt), 0);
        check("t1_mem_req", 32'(bus.mem_req), 1);
        check("t1_addr", bus.mem_addr, 32'h4);
        check("t1_be", 32'(bus.mem_be), 32'hF);
        check("t1_we", 32'(bus.mem_we), 0);
        @(negedge clk);
        idle(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        #1;
        check("t1_if_rvalid", 32'(bus.if_rvalid), 1);
        check("t1_if_rdata", bus.if_rdata, 32'h1234_5678);
        check("t1_ls_rvalid", 32'(bus.ls_rvalid), 0);

        // Contention: LS write wins, IF follows
        @(negedge clk);
        idle();
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_be = 4'h3;
        bus.ls_addr = 32'h100; bus.ls_wdata = 32'hDEAD_BEEF; bus.mem_gnt = 1'b1;
        #1;
        check("t2_ls_gnt", 32'(bus.ls_gnt), 1);
        check("t2_if_gnt", 32'(bus.if_gnt), 0);
        check("t2_we", 32'(bus.mem_we), 1);
        check("t2_be", 32'(bus.mem_be), 32'h3);
        check("t2_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("t2_addr", bus.mem_addr, 32'h100);
        @(negedge clk);
        bus.ls_req = 1'b0; bus.ls_we = 1'b0;
        #1;
        check("t2_if_gnt_next", 32'(bus.if_gnt), 1);
        check("t2_if_addr_next", bus.mem_addr, 32'h40);
        @(negedge clk);
        idle(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hB1;
        #1;
        check("t2_ls_rvalid", 32'(bus.ls_rvalid), 1);
        check("t2_if_rvalid0", 32'(bus.if_rvalid), 0);
        @(negedge clk);
        idle(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hB2;
        #1;
        check("t2_if_rvalid1", 32'(bus.if_rvalid), 1);

        // Queue full blocks grants; pop cycle does not grant
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle(); bus.if_req = 1'b1; bus.if_addr = 32'h200; bus.mem_gnt = 1'b1;
            if (k == 3) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA003;
            end
            #1;
            check($sformatf("t3_if_gnt_%0d", k), 32'(bus.if_gnt), 32'(k == 0 || k == 1 || k == 4));
            check($sformatf("t3_mem_req_%0d", k), 32'(bus.mem_req), 32'(k == 0 || k == 1 || k == 4));
            if (k == 3) check("t3_if_rvalid", 32'(bus.if_rvalid), 1);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            idle(); bus.mem_rvalid = 1'b1;
            #1;
            check($sformatf("t3_drain_%0d", k), 32'(bus.if_rvalid), 1);
        end

        // Interleaved owners IF, LS, IF with in-order responses
        @(negedge clk);
        idle(); bus.if_req = 1'b1; bus.if_addr = 32'h10; bus.mem_gnt = 1'b1;
        #1;
        check("t4_gnt_a", 32'(bus.if_gnt), 1);
        @(negedge clk);
        idle(); bus.ls_req = 1'b1; bus.ls_addr = 32'h20; bus.ls_be = 4'hF; bus.mem_gnt = 1'b1;
        #1;
        check("t4_gnt_b", 32'(bus.ls_gnt), 1);
        @(negedge clk);
        idle(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAAAA;
        #1;
        check("t4_rsp_a_if", 32'(bus.if_rvalid), 1);
        check("t4_rsp_a_ls", 32'(bus.ls_rvalid), 0);
        @(negedge clk);
        idle(); bus.if_req = 1'b1; bus.if_addr = 32'h30; bus.mem_gnt = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBBBB;
        #1;
        check("t4_gnt_c", 32'(bus.if_gnt), 1);
        check("t4_rsp_b_ls", 32'(bus.ls_rvalid), 1);
        check("t4_rsp_b_if", 32'(bus.if_rvalid), 0);
        check("t4_rsp_b_data", bus.ls_rdata, 32'hBBBB);
        @(negedge clk);
        idle(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCCCC;
        #1;
        check("t4_rsp_c_if", 32'(bus.if_rvalid), 1);
        check("t4_rsp_c_ls", 32'(bus.ls_rvalid), 0);

        // Stray response with empty queue, then normal IF read
        @(negedge clk);
        idle(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD;
        #1;
        check("t5_stray_if", 32'(bus.if_rvalid), 0);
        check("t5_stray_ls", 32'(bus.ls_rvalid), 0);
        @(negedge clk);
        idle(); bus.if_req = 1'b1; bus.if_addr = 32'h44; bus.mem_gnt = 1'b1;
        #1;
        check("t5_if_gnt", 32'(bus.if_gnt), 1);
        check("t5_addr", bus.mem_addr, 32'h44);
        @(negedge clk);
        idle(); bus.mem_rvalid = 1'b1;
        #1;
        check("t5_if_rvalid", 32'(bus.if_rvalid), 1);

        // Reset with two outstanding
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            idle(); bus.if_req = 1'b1; bus.if_addr = 32'h50; bus.mem_gnt = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_if_gnt_in_rst", 32'(bus.if_gnt), 0);
        check("t6_mem_req_in_rst", 32'(bus.mem_req), 0);
        @(negedge clk);
        idle(); rst_n = 1'b1; bus.mem_rvalid = 1'b1;
        #1;
        check("t6_late_rsp_if", 32'(bus.if_rvalid), 0);
        check("t6_late_rsp_ls", 32'(bus.ls_rvalid), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            idle(); bus.if_req = 1'b1; bus.if_addr = 32'h60; bus.mem_gnt = 1'b1;
            #1;
            check($sformatf("t6_regrant_%0d", k), 32'(bus.if_gnt), 1);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            idle(); bus.mem_rvalid = 1'b1;
        end

`ifdef KAMIKAZE_ARB_RR_EN
        // Round-robin alternation from reset pointer
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle();
            bus.if_req = 1'b1; bus.if_addr = 32'h80;
            bus.ls_req = 1'b1; bus.ls_addr = 32'h90; bus.ls_be = 4'hF;
            bus.mem_gnt = 1'b1;
            if (k > 0) bus.mem_rvalid = 1'b1;
            #1;
            check($sformatf("rr_if_gnt_%0d", k), 32'(bus.if_gnt), 32'(k % 2 == 0));
            check($sformatf("rr_ls_gnt_%0d", k), 32'(bus.ls_gnt), 32'(k % 2 == 1));
        end
        @(negedge clk);
        idle(); bus.mem_rvalid = 1'b1;
`endif

        // Randomized traffic against the owner-queue model
        reset_pulse();
        q.delete();
        rr_m   = 1'b0;
        if_act = 1'b0;
        ls_act = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            if (!if_act && $urandom_range(0, 1) == 1) begin
                if_act      = 1'b1;
                bus.if_addr = $urandom;
            end
            bus.if_req = if_act;
            if (!ls_act && $urandom_range(0, 1) == 1) begin
                ls_act       = 1'b1;
                bus.ls_we    = 1'($urandom_range(0, 1));
                bus.ls_be    = 4'($urandom);
                bus.ls_addr  = $urandom;
                bus.ls_wdata = $urandom;
            end
            bus.ls_req    = ls_act;
            bus.mem_gnt   = ($urandom_range(0, 3) != 0);
            bus.mem_rdata = $urandom;
            if (q.size() > 0) bus.mem_rvalid = ($urandom_range(0, 2) == 0);
            else              bus.mem_rvalid = ($urandom_range(0, 7) == 0);

            full = (q.size() == MAX_OUT);
`ifdef KAMIKAZE_ARB_RR_EN
            win_ls = ls_act && (!if_act || rr_m);
`else
            win_ls = ls_act;
`endif
            e_req   = (if_act || ls_act) && !full;
            e_xfer  = e_req && bus.mem_gnt;
            pop     = bus.mem_rvalid && (q.size() > 0);
            head_ls = (q.size() > 0) ? (q[0] == 1) : 1'b0;
            #1;
            check("rnd_mem_req", 32'(bus.mem_req), 32'(e_req));
            check("rnd_if_gnt", 32'(bus.if_gnt), 32'(e_xfer && !win_ls));
            check("rnd_ls_gnt", 32'(bus.ls_gnt), 32'(e_xfer && win_ls));
            check("rnd_if_rvalid", 32'(bus.if_rvalid), 32'(pop && !head_ls));
            check("rnd_ls_rvalid", 32'(bus.ls_rvalid), 32'(pop && head_ls));
            check("rnd_if_rdata", bus.if_rdata, bus.mem_rdata);
            check("rnd_ls_rdata", bus.ls_rdata, bus.mem_rdata);
            if (e_req) begin
                check("rnd_addr", bus.mem_addr, (win_ls ? bus.ls_addr : bus.if_addr) & ~32'h3);
                check("rnd_we", 32'(bus.mem_we), 32'(win_ls && bus.ls_we));
                check("rnd_be", 32'(bus.mem_be), 32'(win_ls ? bus.ls_be : 4'hF));
                check("rnd_wdata", bus.mem_wdata, win_ls ? bus.ls_wdata : 32'h0);
            end

            if (pop) void'(q.pop_front());
            if (e_xfer) begin
                q.push_back(win_ls ? 1 : 0);
                rr_m = !win_ls;
                if (win_ls) ls_act = 1'b0;
                else        if_act = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kamikaze_imem_arbiter.md
Name: kamikaze_imem_arbiter

Overview:
- Shares one 32-bit synchronous memory port between the instruction fetch unit (IF) and the load/store unit (LS).
- Arbitrates requests and issues the winner to memory.
- Tracks outstanding transactions in an in-order owner queue.
- Routes each memory response back to the requester that issued it.
- Sits between the fetch/LSU stages and the unified memory.

Parameters:
- MAX_OUTSTANDING, 2: depth of the owner queue, i.e. maximum accepted but unanswered transactions (power of two, 1..8).
- RESET_OWNER_RR, 0: initial round-robin pointer (0 = IF favoured next, 1 = LS); used only with the optional feature.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-low
- if_req_i  input  1  IF read request
- if_addr_i  input  32  IF byte address
- if_gnt_o  output  1  IF request accepted this cycle
- if_rvalid_o  output  1  IF read data valid
- if_rdata_o  output  32  IF read data
- ls_req_i  input  1  LS request
- ls_we_i  input  1  LS write enable
- ls_be_i  input  4  LS byte enables
- ls_addr_i  input  32  LS byte address
- ls_wdata_i  input  32  LS write data
- ls_gnt_o  output  1  LS request accepted this cycle
- ls_rvalid_o  output  1  LS response valid (read data or write ack)
- ls_rdata_o  output  32  LS read data
- mem_req_o  output  1  memory request
- mem_we_o  output  1  memory write enable
- mem_be_o  output  4  memory byte enables
- mem_addr_o  output  32  memory word address (bits [1:0] forced 00)
- mem_wdata_o  output  32  memory write data
- mem_gnt_i  input  1  memory accepted request this cycle
- mem_rvalid_i  input  1  memory response valid (in order, at least 1 cycle after grant, one per accepted transaction including writes)
- mem_rdata_i  input  32  memory read data

Behaviour:
- Reset (rst_i low, asynchronous):
  - owner queue empty, count = 0
  - all gnt/rvalid outputs 0; mem_req_o 0
  - rr pointer = RESET_OWNER_RR
- Handshake:
  - A requester holds req and payload stable until its gnt.
  - gnt is combinational, same cycle as mem_gnt_i.
  - Transfer occurs when req & gnt.
- Selection (combinational):
  - Default: fixed priority, LS over IF.
  - Only one requester is selected per cycle.
  - mem_req_o = selected req & !queue_full.
  - mem_we_o / mem_be_o / mem_wdata_o come from LS when LS is selected.
  - When IF is selected: mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
- Grant:
  - sel_gnt_o = mem_gnt_i & mem_req_o & selected.
  - The non-selected gnt is 0.
- Owner queue:
  - On each granted transfer, push the owner bit (0 = IF, 1 = LS).
  - On mem_rvalid_i, pop.
  - Push and pop in the same cycle leave count unchanged; this is legal even when full.
  - Full: count == MAX_OUTSTANDING. mem_req_o is held 0 and no grants are issued.
  - Because full blocks new grants, a same-cycle pop cannot make room for a grant in that cycle.
- Response routing:
  - if_rvalid_o = mem_rvalid_i & head owner == IF; ls_rvalid_o likewise for LS.
  - Both rdata outputs are driven by mem_rdata_i.
  - Rvalid outputs are combinational, zero added latency.
- mem_rvalid_i arriving with an empty queue is a protocol error. It is ignored (no rvalid out, count stays 0).
- Reset mid-transaction drops all outstanding entries. Responses arriving after reset are ignored per the empty-queue rule.
- Request latency adds 0 cycles; responses pass straight through.

Optional Feature:
- Macro KAMIKAZE_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both requesters are active, the one indicated by the rr pointer wins.
  - After each granted transfer, the pointer flips to the other requester.
  - A single active requester always wins; the pointer still updates to the non-winner.
- Undefined: fixed LS priority as described above; the pointer register is absent.

Test Plan:
- Reset then IF req, addr 0x00000006, mem_gnt_i=1 -> same cycle if_gnt_o=1, mem_addr_o=0x00000004, mem_be_o=F. Next cycle mem_rvalid_i=1, rdata 0x12345678 -> if_rvalid_o=1, if_rdata_o=0x12345678, ls_rvalid_o=0.
- IF and LS request together, LS write 0xDEADBEEF to 0x100 with be=3, feature off -> ls_gnt_o=1, if_gnt_o=0, mem_we_o=1, mem_be_o=3. IF granted next cycle.
- MAX_OUTSTANDING=2, memory delays rvalid 3 cycles, IF requests continuously -> 2 grants, then mem_req_o=0 until first rvalid. In the rvalid cycle if_gnt_o stays 0; the next grant occurs the following cycle.
- Interleaved grants IF, LS, IF with in-order responses A, B, C -> if_rvalid_o for A, ls_rvalid_o for B, if_rvalid_o for C.
- KAMIKAZE_ARB_RR_EN defined, both requesting continuously, RESET_OWNER_RR=0 -> grant order IF, LS, IF, LS.
- mem_rvalid_i pulse after reset with no request -> no rvalid outputs, next IF request handled normally. Assert rst_i with 2 outstanding -> count 0 and gnt 0 immediately.
